act_buf_writer: RTL and testbench

Write side of the activation input ping-pong buffer. It accepts a stream of 64-bit activation words (16 × 4-bit values per word) from the external load path and writes one tile of words into the bank selected by the ping-pong controller, at sequential addresses. When the tile is complete it pulses `finished`, which drives the controller's `write_finish` input. The read-address side consumes the same banks.

---
 rtl/act_buf_writer.sv | 123 ++++++++++++
 tb/tb_act_buf_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/act_buf_writer.sv
// -----------------------------------------------------------------------------
// act_buf_writer
//
// Write side of the activation ping-pong input buffer. One tile of 64-bit
// activation words (16 x 4-bit values each) is taken from the load stream and
// written at addresses 0..words-1 of the bank that the ping-pong controller
// selects. When the last word has been written, a one-cycle `finished` pulse
// is raised for the controller's write_finish input.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       request one tile (sampled only when idle)
//   tile_words  words in the tile, latched on an accepted start, saturated to DEPTH
//   bank_sel    write bank from the ping-pong controller
//   bank_free   target bank may be overwritten
//   s_valid     input word valid
//   s_data      input word
//   s_ready     a word is accepted this cycle when s_valid is also high
//   wr_en       buffer write strobe (registered)
//   wr_bank     bank written by wr_en (registered, frozen for the whole tile)
//   wr_addr     buffer write address (registered)
//   wr_data     buffer write data (registered)
//   finished    one-cycle pulse once the tile is fully written
//   busy        high from an accepted start through the finished pulse
// -----------------------------------------------------------------------------
module act_buf_writer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   tile_words,
  input  logic              bank_sel,
  input  logic              bank_free,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              finished,
  output logic              busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_BANK = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] FLUSH     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  // The counter is one bit wider than the address so a full bank (DEPTH
  // words) is representable as a tile length.
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);

  // A tile never exceeds one bank, so addresses can never wrap.
  function automatic logic [ADDR_W:0] sat_words(input logic [ADDR_W:0] req);
    return (req > MAX_WORDS) ? MAX_WORDS : req;
  endfunction

  logic [2:0]      state;
  logic [ADDR_W:0] words;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_next;
  logic            hs_p0;

  // Stage p0: handshake on the input stream. While in WRITE the accepted
  // count is always below `words`, because the final handshake leaves WRITE.
  assign s_ready  = (state == WRITE);
  assign hs_p0    = s_valid && s_ready;
  assign cnt_next = cnt + 1'b1;
  assign finished = (state == DONE);
  assign busy     = (state != IDLE);

  // Stage p1: registered buffer write port and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      words   <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            words <= sat_words(tile_words);
            cnt   <= '0;
            state <= WAIT_BANK;
          end
        end
        WAIT_BANK: begin
          // The bank is captured once here and held until the next tile,
          // so later bank_sel changes cannot split a tile across banks.
          if (bank_free) begin
            wr_bank <= bank_sel;
            state   <= (words == '0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (hs_p0) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_W-1:0];
            wr_data <= s_data;
            cnt     <= cnt_next;
            if (cnt_next == words) state <= FLUSH;
          end
        end
        // The last word's write strobe is on the port during FLUSH.
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_buf_writer.sv
module tb_act_buf_writer;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   tile_words = '0;
  logic              bank_sel = 1'b0;
  logic              bank_free = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              finished;
  logic              busy;

  act_buf_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_words(tile_words),
    .bank_sel(bank_sel), .bank_free(bank_free), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .finished(finished), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: words accepted on the stream (in order) and the
  // writes seen on the buffer port.
  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [DATA_W-1:0] acc_q[$];
  wr_t               obs_q[$];
  int  cyc = 0, hs_cnt = 0, fin_cnt = 0, exp_words = 0;
  int  last_wr_cyc = -1, fin_cyc = -1;
  logic hs_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hs_prev = 1'b0;
    end else begin
      // A write appears exactly one cycle after each accepted word.
      check("wr_en_latency", wr_en, hs_prev);
      if (s_ready) check("ready_bound", hs_cnt < exp_words, 1);
      hs_prev = s_valid && s_ready;
      if (hs_prev) begin
        acc_q.push_back(s_data);
        hs_cnt++;
      end
      if (wr_en) begin
        obs_q.push_back({wr_bank, wr_addr, wr_data});
        last_wr_cyc = cyc;
      end
      if (finished) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic clear_model(input int words);
    acc_q.delete();
    obs_q.delete();
    hs_cnt = 0;
    fin_cnt = 0;
    exp_words = words;
    last_wr_cyc = -1;
    fin_cyc = -1;
  endtask

  task automatic run_tile(input int tw, input logic bsel, input int free_delay,
                          input bit alt, input int pct, input bit toggle_sel,
                          input bit poke_start);
    int words, bad, budget, last_hs;
    words = (tw > DEPTH) ? DEPTH : tw;
    @(posedge clk); #1;
    clear_model(words);
    start = 1'b1;
    tile_words = tw[ADDR_W:0];
    bank_sel = bsel;
    bank_free = (free_delay == 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < free_delay; i++) begin
      check("gate_ready", s_ready, 0);
      check("gate_wr", wr_en, 0);
      bank_sel = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bank_sel = bsel;
    bank_free = 1'b1;
    budget = 0;
    last_hs = hs_cnt;
    while (fin_cnt == 0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      if (fin_cnt != 0) break;
      if (alt) begin
        s_valid = !s_valid;
        if (s_valid) s_data = {$urandom, $urandom};
      end else if (!s_valid || hs_cnt != last_hs) begin
        s_valid = ($urandom_range(99) < pct);
        s_data = {$urandom, $urandom};
      end
      last_hs = hs_cnt;
      if (toggle_sel) bank_sel = 1'($urandom_range(1));
      if (poke_start) begin
        start = 1'($urandom_range(1));
        tile_words = ADDR_W'($urandom_range(1, 9));
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    check("tile_timeout", budget < 3000, 1);
    check("busy_after_fin", busy, 0);
    check("fin_low_after", finished, 0);
    check("fin_count", fin_cnt, 1);
    check("hs_count", hs_cnt, words);
    check("wr_count", obs_q.size(), words);
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (i >= acc_q.size() || int'(obs_q[i].addr) != i ||
          obs_q[i].data !== acc_q[i] || obs_q[i].bank !== bsel)
        bad++;
    end
    check("wr_content", bad, 0);
    if (words > 0) check("fin_timing", fin_cyc, last_wr_cyc + 1);
    @(posedge clk); #1;
    check("idle_stays", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_bank"}, wr_bank, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int budget, last_hs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Basic tile, stream always valid.
    run_tile(4, 1'b1, 0, 1'b0, 100, 1'b0, 1'b0);
    // Backpressure with alternating valid.
    run_tile(3, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    // Bank gating, then bank_sel toggling mid-tile.
    run_tile(5, 1'b0, 10, 1'b0, 70, 1'b1, 1'b0);
    // Bounds: empty tile and oversize tile.
    run_tile(0, 1'b1, 0, 1'b0, 100, 1'b0, 1'b0);
    run_tile(600, 1'b0, 0, 1'b0, 85, 1'b1, 1'b0);

    // Reset in the middle of an 8-word tile after 5 words.
    @(posedge clk); #1;
    clear_model(8);
    start = 1'b1;
    tile_words = 10'd8;
    bank_sel = 1'b1;
    bank_free = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = {$urandom, $urandom};
    budget = 0;
    last_hs = 0;
    while (hs_cnt < 5 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
      if (hs_cnt != last_hs) s_data = {$urandom, $urandom};
      last_hs = hs_cnt;
    end
    check("rst_wait_timeout", budget < 100, 1);
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    check_reset_values("midrst");
    check("rst_partial_hs", hs_cnt, 5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_finished", fin_cnt, 0);
    check("rst_idle", busy, 0);
    run_tile(2, 1'b0, 0, 1'b0, 100, 1'b0, 1'b0);

    // Ping-pong: bank flips after each finished; start poked while busy.
    run_tile(4, 1'b1, 0, 1'b0, 80, 1'b0, 1'b1);
    run_tile(4, 1'b0, 0, 1'b0, 80, 1'b0, 1'b1);

    // Random tiles.
    for (int t = 0; t < 6; t++) begin
      run_tile($urandom_range(1, 40), 1'($urandom_range(1)), $urandom_range(0, 3),
               1'b0, $urandom_range(40, 100), 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
